pslip_req_gen: RTL and testbench
================================

// Module: pslip_req_gen
// PURPOSE
//  Input-port request generator for the pSLIP scheduler: the sending end of the
//  priority-request interface that pri_sel_comb consumes. Holds per-output
//  virtual output queues (VOQs) of cell priorities and presents one request per
//  output (valid + priority code). Pops a VOQ head when the scheduler grants it.
//  Ages waiting heads so low-priority traffic cannot starve.
// PARAMETERS
//  N       4   number of outputs / request lanes (VOQs)
//  P       16  number of priority levels; codes 0..P-1, larger = more urgent
//  DEPTH   4   entries per VOQ FIFO (power of two, >=2)
//  AGE_TH  8   cycles a head waits ungranted per +1 priority bonus (>=1)
// PORTS
//  clk        in   1                clock, rising edge
//  reset      in   1                asynchronous, active-low reset
//  arr_valid  in   1                arriving cell present
//  arr_dst    in   $clog2(N)        destination lane of arriving cell
//  arr_pri    in   $clog2(P)        priority of arriving cell
//  arr_ready  out  1                lane arr_dst can accept (combinational)
//  gnt_valid  in   1                scheduler grant this cycle
//  gnt_idx    in   $clog2(N)        granted lane
//  req_valid  out  N                lane i has a queued head (registered)
//  req_pri    out  $clog2(P) x N    unpacked [0:N-1]; effective head priority (registered)
//  err        out  1                sticky: grant received for an empty lane
// BEHAVIOUR
//  Reset (reset=0, async): all FIFO pointers, counts, age counters, bonuses = 0;
//   req_valid = 0; every req_pri[i] = 0; err = 0. Memory contents are don't-care.
//  Arrival: accepted on the clk edge when arr_valid && arr_ready.
//   arr_ready = (count[arr_dst] != DEPTH). Depends only on the current count;
//   a same-cycle grant never creates room (no bypass).
//   Accepted arr_pri is written at the lane tail. Count wraps pointers mod DEPTH.
//  Grant: on the edge with gnt_valid, lane gnt_idx pops its head if count > 0.
//   Grant to an empty lane: no state change except err <= 1 (held until reset).
//   A grant whose gnt_idx >= N (non-power-of-two N) is treated the same way.
//  Simultaneous arrival + grant:
//   - Same lane, non-empty, not full: push and pop both occur; count unchanged.
//   - Same lane, empty: arrival is stored, grant sets err, count becomes 1.
//   - Same lane, full: arrival refused (arr_ready=0), pop occurs, count = DEPTH-1.
//   - Different lanes: both occur independently.
//  Outputs are registered from next state, one-cycle latency:
//   - Arrival into an empty lane at edge t: req_valid[i]=1, req_pri[i]=arr_pri after t.
//   - Pop at edge t: the next head, or req_valid[i]=0 with req_pri[i]=0 if empty, after t.
//   - req_pri[i] = min(head_pri + bonus[i], P-1). An empty lane shows 0.
//  Aging, per lane:
//   - age[i] and bonus[i] clear to 0 whenever the head changes (pop) or the lane is empty.
//   - Otherwise age[i] increments each cycle. When age[i] reaches AGE_TH-1 it clears
//     and bonus[i] increments, saturating so head_pri + bonus never exceeds P-1.
//   - Counter widths are sized to hold AGE_TH-1 and P-1 with no wrap.
//  No internal state machine beyond the per-lane FIFO/aging state. All lanes are
//   updated in parallel every cycle.
//  Reset asserted mid-operation discards all queued cells immediately. arr_ready
//   then reads 1 for every lane.
// TESTING
//  1 Reset: hold reset=0 while driving traffic -> req_valid=0, all req_pri=0,
//    err=0, arr_ready=1; release reset -> same values until the first arrival.
//  2 Arrival/latency: push pri 5 to lane 2 at edge t -> after t, req_valid=4'b0100
//    and req_pri[2]=5; grant lane 2 at t+1 -> after t+1, req_valid=0, req_pri[2]=0.
//  3 Full + FIFO order: push pris 1,2,3,4 to lane 0 -> arr_ready=0 for dst 0;
//    a 5th push is refused. Grants then show heads 2,3,4 and finally valid=0.
//  4 Simultaneous: lane 1 full, arrival + grant on lane 1 in the same cycle -> arrival
//    dropped, count 3. Lane 3 holding 1 entry with push+pop -> count stays 1,
//    new head = the pushed pri.
//  5 Aging, AGE_TH=8: head pri 14 ungranted -> req_pri 14 for 8 cycles, then 15,
//    and it stays at 15 (saturated). Pop at any point -> the next head shows its raw pri.
//  6 Error: grant lane 1 while it is empty -> err=1 next cycle and sticky, no other
//    state change. Assert reset -> err=0.

Source files
------------

// File: rtl/pslip_req_gen.sv
// Input-port request generator for the pSLIP scheduler: per-output VOQs of cell
// priorities, one registered request per lane, grant-driven pops and head aging.
module pslip_req_gen #(
   parameter  int N      = 4,
   parameter  int P      = 16,
   parameter  int DEPTH  = 4,
   parameter  int AGE_TH = 8,
   localparam int NW     = (N > 1) ? $clog2(N) : 1,
   localparam int PW     = (P > 1) ? $clog2(P) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          arr_valid,
   input  logic [NW-1:0] arr_dst,
   input  logic [PW-1:0] arr_pri,
   output logic          arr_ready,
   input  logic          gnt_valid,
   input  logic [NW-1:0] gnt_idx,
   output logic [N-1:0]  req_valid,
   output logic [PW-1:0] req_pri [0:N-1],
   output logic          err
);
   localparam int DW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (AGE_TH > 1) ? $clog2(AGE_TH) : 1;
   localparam int SW = PW + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [AW-1:0] AGE_LAST = AW'(AGE_TH - 1);
   localparam logic [SW-1:0] PRI_MAX  = SW'(P - 1);

   logic [PW-1:0] mem_q       [N][DEPTH];
   logic [CW-1:0] count_q     [N];
   logic [CW-1:0] count_d     [N];
   logic [DW-1:0] rd_q        [N];
   logic [DW-1:0] rd_d        [N];
   logic [DW-1:0] wr_q        [N];
   logic [DW-1:0] wr_d        [N];
   logic [AW-1:0] age_q       [N];
   logic [AW-1:0] age_d       [N];
   logic [PW-1:0] bonus_q     [N];
   logic [PW-1:0] bonus_d     [N];
   logic [PW-1:0] req_pri_q   [0:N-1];
   logic [PW-1:0] req_pri_d   [0:N-1];
   logic [N-1:0]  req_valid_q, req_valid_d;
   logic          err_q, err_d;
   logic [N-1:0]  push;

   // Readiness looks only at the current count, so a same-cycle pop never makes room.
   always_comb begin
      arr_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (arr_dst == NW'(i)) arr_ready = (count_q[i] != FULL);
      end
   end

   always_comb begin
      logic          pop;
      logic          gnt_ok;
      logic [CW-1:0] rem;
      logic [PW-1:0] head_cur;
      logic [PW-1:0] head_nxt;
      logic [SW-1:0] sum;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      pop         = 1'b0;
      gnt_ok      = 1'b0;
      rem         = '0;
      head_cur    = '0;
      head_nxt    = '0;
      sum         = '0;
      push        = '0;
      req_valid_d = '0;
      for (int i = 0; i < N; i++) begin
         push[i]    = arr_valid && arr_ready && (arr_dst == NW'(i));
         pop        = gnt_valid && (gnt_idx == NW'(i)) && (count_q[i] != '0);
         gnt_ok     = gnt_ok | pop;
         rem        = count_q[i] - CW'(pop);
         count_d[i] = rem + CW'(push[i]);
         wr_d[i]    = wr_q[i] + DW'(push[i]);
         rd_d[i]    = rd_q[i] + DW'(pop);
         head_cur   = mem_q[i][rd_q[i]];

         if (pop || count_q[i] == '0) begin
            age_d[i]   = '0;
            bonus_d[i] = '0;
         end else if (age_q[i] == AGE_LAST) begin
            age_d[i]   = '0;
            bonus_d[i] = bonus_q[i];
            if (({1'b0, head_cur} + {1'b0, bonus_q[i]}) < PRI_MAX)
               bonus_d[i] = bonus_q[i] + PW'(1);
         end else begin
            age_d[i]   = age_q[i] + AW'(1);
            bonus_d[i] = bonus_q[i];
         end

         // A push into a lane that is (or becomes) empty is its own new head.
         head_nxt       = (push[i] && rem == '0) ? arr_pri : mem_q[i][rd_d[i]];
         sum            = {1'b0, head_nxt} + {1'b0, bonus_d[i]};
         req_valid_d[i] = (count_d[i] != '0);
         req_pri_d[i]   = !req_valid_d[i] ? '0 :
                          (sum > PRI_MAX) ? PRI_MAX[PW-1:0] : sum[PW-1:0];
      end
      err_d = err_q | (gnt_valid & ~gnt_ok);
   end

   // NOTE: sequential state uses non-blocking assignments so all lanes update from the same old values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            count_q[i]   <= '0;
            rd_q[i]      <= '0;
            wr_q[i]      <= '0;
            age_q[i]     <= '0;
            bonus_q[i]   <= '0;
            req_pri_q[i] <= '0;
         end
         req_valid_q <= '0;
         err_q       <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            count_q[i]   <= count_d[i];
            rd_q[i]      <= rd_d[i];
            wr_q[i]      <= wr_d[i];
            age_q[i]     <= age_d[i];
            bonus_q[i]   <= bonus_d[i];
            req_pri_q[i] <= req_pri_d[i];
         end
         req_valid_q <= req_valid_d;
         err_q       <= err_d;
      end
   end

   // NOTE: the VOQ storage is not reset; counts and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (push[i]) mem_q[i][wr_q[i]] <= arr_pri;
      end
   end

   assign req_valid = req_valid_q;
   assign req_pri   = req_pri_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pslip_req_gen.sv
// Scoreboard bench for pslip_req_gen: a queue-based lane model predicts each
// post-edge output set, and a separate monitor compares it against the DUT.
module tb_pslip_req_gen;
   localparam int N      = 4;
   localparam int P      = 16;
   localparam int DEPTH  = 4;
   localparam int AGE_TH = 8;
   localparam int NW     = $clog2(N);
   localparam int PW     = $clog2(P);

   typedef struct packed {
      logic                 rdy;
      logic                 err;
      logic [N-1:0]         v;
      logic [N-1:0][PW-1:0] pri;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          arr_valid = 1'b0;
   logic [NW-1:0] arr_dst = '0;
   logic [PW-1:0] arr_pri = '0;
   logic          arr_ready;
   logic          gnt_valid = 1'b0;
   logic [NW-1:0] gnt_idx = '0;
   logic [N-1:0]  req_valid;
   logic [PW-1:0] req_pri [0:N-1];
   logic          err;

   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];

   // Reference model: one queue of priorities per lane plus cycles the head has waited.
   int   mq     [N][$];
   int   waited [N];
   logic m_err = 1'b0;

   pslip_req_gen #(.N(N), .P(P), .DEPTH(DEPTH), .AGE_TH(AGE_TH)) dut (
      .clk       (clk),
      .reset     (reset),
      .arr_valid (arr_valid),
      .arr_dst   (arr_dst),
      .arr_pri   (arr_pri),
      .arr_ready (arr_ready),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .req_valid (req_valid),
      .req_pri   (req_pri),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive at the falling edge, advance the model, queue the expectation.
   task automatic cyc(input logic rst, input logic av, input int ad, input int ap,
                      input logic gv, input int gi);
      exp_t e;
      logic pushok, gok, was_empty, popl;
      int   b;
      @(negedge clk);
      reset     = rst;
      arr_valid = av;
      arr_dst   = NW'(ad);
      arr_pri   = PW'(ap);
      gnt_valid = gv;
      gnt_idx   = NW'(gi);
      if (!rst) begin
         for (int l = 0; l < N; l++) begin
            mq[l].delete();
            waited[l] = 0;
         end
         m_err = 1'b0;
      end else begin
         pushok = av && (mq[ad].size() != DEPTH);
         gok    = gv && (gi < N) && (mq[gi].size() > 0);
         if (gv && !gok) m_err = 1'b1;
         for (int l = 0; l < N; l++) begin
            was_empty = (mq[l].size() == 0);
            popl      = gok && (gi == l);
            if (popl) void'(mq[l].pop_front());
            if (pushok && ad == l) mq[l].push_back(ap);
            waited[l] = (popl || was_empty) ? 0 : waited[l] + 1;
         end
      end
      e     = '0;
      e.err = m_err;
      e.rdy = (mq[ad].size() != DEPTH);
      for (int l = 0; l < N; l++) begin
         if (mq[l].size() > 0) begin
            b = waited[l] / AGE_TH;
            if (b > P - 1 - mq[l][0]) b = P - 1 - mq[l][0];
            e.v[l]   = 1'b1;
            e.pri[l] = PW'(mq[l][0] + b);
         end
      end
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 0);
   endtask

   // Monitor: one expectation per clock, compared just after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("req_valid", 32'(req_valid), 32'(e.v));
            for (int l = 0; l < N; l++)
               check($sformatf("req_pri[%0d]", l), 32'(req_pri[l]), 32'(e.pri[l]));
            check("err", 32'(err), 32'(e.err));
            check("arr_ready", 32'(arr_ready), 32'(e.rdy));
         end
      end
   end

   initial begin
      // Reset held while traffic is driven, then released with no arrivals.
      cyc(1'b0, 1'b1, 1, 9, 1'b1, 2);
      cyc(1'b0, 1'b1, 3, 4, 1'b1, 0);
      cyc(1'b0, 1'b1, 0, 7, 1'b0, 0);
      idle(2);

      // Single arrival then grant on lane 2.
      cyc(1'b1, 1'b1, 2, 5, 1'b0, 0);
      cyc(1'b1, 1'b0, 0, 0, 1'b1, 2);

      // Fill lane 0, refused fifth push, drain in FIFO order.
      for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b1, 0, k, 1'b0, 0);
      cyc(1'b1, 1'b1, 0, 9, 1'b0, 0);
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 0, 0, 1'b1, 0);

      // Full lane with push+pop drops the push; one-entry lane swaps its head.
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1, 10 + k, 1'b0, 0);
      cyc(1'b1, 1'b1, 1, 7, 1'b1, 1);
      cyc(1'b1, 1'b1, 3, 6, 1'b0, 0);
      cyc(1'b1, 1'b1, 3, 11, 1'b1, 3);
      idle(1);

      // Aging to saturation, then a pop exposes the raw priority of the next head.
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
      cyc(1'b1, 1'b1, 0, 14, 1'b0, 0);
      idle(12);
      cyc(1'b1, 1'b1, 0, 3, 1'b0, 0);
      idle(2);
      cyc(1'b1, 1'b0, 0, 0, 1'b1, 0);
      idle(10);

      // Grant to an empty lane is sticky until reset.
      cyc(1'b1, 1'b0, 0, 0, 1'b1, 1);
      idle(3);
      cyc(1'b0, 1'b0, 0, 0, 1'b0, 0);
      idle(1);

      // Randomized traffic with occasional mid-run resets.
      for (int k = 0; k < 600; k++) begin
         cyc(($urandom_range(0, 59) != 0),
             ($urandom_range(0, 9) < 7), $urandom_range(0, N - 1), $urandom_range(0, P - 1),
             ($urandom_range(0, 9) < 5), $urandom_range(0, N - 1));
      end
      idle(2);

      @(posedge clk);
      #2;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
